contador_mais_menos_param: RTL and testbench
============================================

Name: contador_mais_menos_param

Overview:
Parametrised up/down counter for operator-adjustable settings (e.g. drone speed level), replacing the fixed 1..5 counter.
- Configurable width, limits, step size, and saturate-or-wrap mode.
- Counts on button presses (edge-detected), with hold-to-repeat auto-increment/decrement.
- Provides limit flags and event pulses for the control unit and displays.

Parameters:
WIDTH, 3, counter width in bits
MIN, 1, lower limit (0 <= MIN < MAX < 2^WIDTH)
MAX, 5, upper limit
STEP, 1, increment/decrement amount (1 <= STEP <= MAX-MIN)
WRAP, 0, 0 = saturate at limits; 1 = wrap to the opposite limit
REPEAT_DELAY, 50000000, cycles of continuous hold before the first auto-repeat step; 0 disables auto-repeat
REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat steps (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear to MIN, active-high
ld  in  1  synchronous load, active-high
D  in  WIDTH  load value
enp  in  1  count enable
soma  in  1  increment request (level, button-like)
sub  in  1  decrement request (level, button-like)
Q  out  WIDTH  counter value
no_max  out  1  Q == MAX (combinational from Q)
no_min  out  1  Q == MIN (combinational from Q)
mudou  out  1  one-cycle pulse: Q changed by a step
limite  out  1  one-cycle pulse: step blocked at limit (WRAP=0) or wrap occurred (WRAP=1)

Behaviour:
- Reset state (asynchronous): Q=MIN, mudou=0, limite=0, FSM=IDLE, repeat timer=0, edge registers=0.
- Priority each clock edge: clr > ld > step.
  - clr or ld: forces FSM to IDLE and timer to 0; mudou=0, limite=0.
- Load: Q <= clamp(D, MIN, MAX).
- Edge detection:
  - soma_d and sub_d register soma and sub every cycle, regardless of enp.
  - Press = soma & ~soma_d (likewise for sub).
- Request validity:
  - dir = up if soma & ~sub; down if sub & ~soma.
  - soma & sub both high: no step; FSM -> IDLE.
- FSM states:
  - IDLE: on press with enp=1 and a valid dir -> one step, timer=0, go to ESPERA (if REPEAT_DELAY=0, stay in IDLE).
  - ESPERA: timer increments while the same dir is held and enp=1. When timer reaches REPEAT_DELAY-1 -> one step, timer=0, go to REPETE.
  - REPETE: timer increments; when timer reaches REPEAT_PERIOD-1 -> one step, timer=0, stay in REPETE.
  - Exit from ESPERA/REPETE: button released, dir change, both buttons high, or enp=0 -> IDLE, timer=0, no step that cycle.
  - A new press of the opposite button from IDLE is handled as a fresh press.
- Step arithmetic: computed in WIDTH+1 bits, no overflow.
  - Up: if Q+STEP <= MAX, Q <= Q+STEP and mudou=1. Otherwise:
    - WRAP=0: Q <= MAX; mudou=1 only if Q != MAX; limite=1.
    - WRAP=1: Q <= MIN; mudou=1; limite=1.
  - Down: symmetric, using MIN and Q-STEP >= MIN.
- Latency: Q updates on the same edge that samples the press, i.e. one cycle after soma rises at the input. mudou and limite are registered and coincide with the new Q.
- enp=0: Q holds; pulses are 0.
  - A button already held when enp rises does not count until it is released and pressed again.
- Timer width: enough bits for max(REPEAT_DELAY, REPEAT_PERIOD).

Test Plan:
- Reset, defaults (W=3, 1..5, STEP=1, WRAP=0): after reset Q=1, no_min=1. Five separate soma presses -> Q = 2,3,4,5,5; 5th press gives limite=1, mudou=0; no_max=1.
- WRAP=1, Q=5, one soma press -> Q=1, mudou=1, limite=1. Then one sub press -> Q=5, limite=1.
- Auto-repeat (REPEAT_DELAY=4, REPEAT_PERIOD=2): hold soma 10 cycles from Q=1 -> steps at cycles 1, 5, 7, 9; Q=5. Release -> FSM returns to IDLE, no further steps.
- ld=1, D=7 -> Q=5. ld=1, D=0 -> Q=1. clr together with ld -> Q=1 (clr wins). soma and sub pressed simultaneously -> Q unchanged, no pulses.
- Hold soma with enp=0, then raise enp -> no step. Release and press again -> one step.
- Assert reset asynchronously mid-repeat (REPETE) -> Q=MIN immediately, pulses 0. After deassertion, a still-held soma does not step until it is re-pressed.

Source files
------------

// File: rtl/contador_mais_menos_param.sv
// Up/down settings counter: edge-detected buttons with hold-to-repeat, saturate or wrap at limits.
// Q, mudou and limite update on the edge that samples a press; no flow control, a step is never stalled.
module contador_mais_menos_param #(
  parameter int WIDTH         = 3,
  parameter int MIN           = 1,
  parameter int MAX           = 5,
  parameter int STEP          = 1,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] D,
  input  logic             enp,
  input  logic             soma,
  input  logic             sub,
  output logic [WIDTH-1:0] Q,
  output logic             no_max,
  output logic             no_min,
  output logic             mudou,
  output logic             limite
);

  localparam int W1   = WIDTH + 1;
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);
  localparam logic [W1-1:0]    MAX_X  = W1'(MAX);
  localparam logic [W1-1:0]    STEP_X = W1'(STEP);

  localparam logic [TW-1:0] DELAY_LAST  = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] PERIOD_LAST = TW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ESPERA = 2'd1,
    REPETE = 2'd2
  } estado_t;

  estado_t          est_q, est_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             mudou_q, mudou_d;
  logic             limite_q, limite_d;
  logic             dir_q, dir_d;
  logic             soma_ant_q, sub_ant_q;
  logic             pronto_q;

  logic             dir_ok, dir_up;
  logic             press_up, press_dn, press_ok;
  logic             do_step, step_up;
  logic             up_ok, dn_ok;
  logic             repete_hit;

  // pronto_q masks the first edge after reset, so a button still held
  // through reset must be released and pressed again before it counts.
  assign press_up = soma & ~soma_ant_q & pronto_q;
  assign press_dn = sub & ~sub_ant_q & pronto_q;
  assign dir_ok   = soma ^ sub;
  assign dir_up   = soma & ~sub;
  assign press_ok = dir_ok & (dir_up ? press_up : press_dn);

  assign up_ok      = ({1'b0, cnt_q} + STEP_X) <= MAX_X;
  assign dn_ok      = cnt_q >= (MIN_N + STEP_N);
  assign repete_hit = (est_q == ESPERA) ? (tmr_q == DELAY_LAST) : (tmr_q == PERIOD_LAST);

  always_comb begin
    est_d    = est_q;
    tmr_d    = tmr_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    mudou_d  = 1'b0;
    limite_d = 1'b0;
    do_step  = 1'b0;
    step_up  = dir_q;

    if (clr) begin
      cnt_d = MIN_N;
      est_d = IDLE;
      tmr_d = '0;
    end else if (ld) begin
      if (D < MIN_N) begin
        cnt_d = MIN_N;
      end else if (D > MAX_N) begin
        cnt_d = MAX_N;
      end else begin
        cnt_d = D;
      end
      est_d = IDLE;
      tmr_d = '0;
    end else begin
      case (est_q)
        IDLE: begin
          if (enp && press_ok) begin
            do_step = 1'b1;
            step_up = dir_up;
            dir_d   = dir_up;
            tmr_d   = '0;
            est_d   = (REPEAT_DELAY > 0) ? ESPERA : IDLE;
          end
        end
        ESPERA, REPETE: begin
          if (!enp || !dir_ok || (dir_up != dir_q)) begin
            est_d = IDLE;
            tmr_d = '0;
          end else if (repete_hit) begin
            do_step = 1'b1;
            tmr_d   = '0;
            est_d   = REPETE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          est_d = IDLE;
          tmr_d = '0;
        end
      endcase

      if (do_step) begin
        if (step_up) begin
          if (up_ok) begin
            cnt_d   = cnt_q + STEP_N;
            mudou_d = 1'b1;
          end else if (WRAP != 0) begin
            cnt_d    = MIN_N;
            mudou_d  = 1'b1;
            limite_d = 1'b1;
          end else begin
            cnt_d    = MAX_N;
            mudou_d  = (cnt_q != MAX_N);
            limite_d = 1'b1;
          end
        end else begin
          if (dn_ok) begin
            cnt_d   = cnt_q - STEP_N;
            mudou_d = 1'b1;
          end else if (WRAP != 0) begin
            cnt_d    = MAX_N;
            mudou_d  = 1'b1;
            limite_d = 1'b1;
          end else begin
            cnt_d    = MIN_N;
            mudou_d  = (cnt_q != MIN_N);
            limite_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      est_q      <= IDLE;
      tmr_q      <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= MIN_N;
      mudou_q    <= 1'b0;
      limite_q   <= 1'b0;
      soma_ant_q <= 1'b0;
      sub_ant_q  <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      est_q      <= est_d;
      tmr_q      <= tmr_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      mudou_q    <= mudou_d;
      limite_q   <= limite_d;
      soma_ant_q <= soma;
      sub_ant_q  <= sub;
      pronto_q   <= 1'b1;
    end
  end

  assign Q      = cnt_q;
  assign no_max = (cnt_q == MAX_N);
  assign no_min = (cnt_q == MIN_N);
  assign mudou  = mudou_q;
  assign limite = limite_q;

endmodule

// File: tb/tb_contador_mais_menos_param.sv
// Three counter configurations share one stimulus stream; a hold-count reference model
// feeds a scoreboard queue that a negedge monitor drains and compares.
module tb_contador_mais_menos_param;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0, ld = 1'b0, enp = 1'b0, soma = 1'b0, sub = 1'b0;
  logic [3:0] d_in = 4'd0;
  logic [2:0] q0, q1;
  logic [3:0] q2;
  logic [2:0] nmax, nmin, mud, lim;

  always #5 clock = ~clock;

  contador_mais_menos_param #(.WIDTH(3), .MIN(1), .MAX(5), .STEP(1), .WRAP(0),
    .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut0 (
    .clock(clock), .reset(reset), .clr(clr), .ld(ld), .D(d_in[2:0]), .enp(enp),
    .soma(soma), .sub(sub), .Q(q0), .no_max(nmax[0]), .no_min(nmin[0]),
    .mudou(mud[0]), .limite(lim[0]));

  contador_mais_menos_param #(.WIDTH(3), .MIN(1), .MAX(5), .STEP(1), .WRAP(1),
    .REPEAT_DELAY(3), .REPEAT_PERIOD(1)) dut1 (
    .clock(clock), .reset(reset), .clr(clr), .ld(ld), .D(d_in[2:0]), .enp(enp),
    .soma(soma), .sub(sub), .Q(q1), .no_max(nmax[1]), .no_min(nmin[1]),
    .mudou(mud[1]), .limite(lim[1]));

  contador_mais_menos_param #(.WIDTH(4), .MIN(2), .MAX(13), .STEP(3), .WRAP(0),
    .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) dut2 (
    .clock(clock), .reset(reset), .clr(clr), .ld(ld), .D(d_in), .enp(enp),
    .soma(soma), .sub(sub), .Q(q2), .no_max(nmax[2]), .no_min(nmin[2]),
    .mudou(mud[2]), .limite(lim[2]));

  int cw[3]    = '{3, 3, 4};
  int cmin[3]  = '{1, 1, 2};
  int cmax[3]  = '{5, 5, 13};
  int cstep[3] = '{1, 1, 3};
  int cwrap[3] = '{0, 1, 0};
  int crd[3]   = '{4, 3, 0};
  int crp[3]   = '{2, 1, 1};

  typedef struct packed {
    logic [2:0][3:0] q;
    logic [2:0]      mud;
    logic [2:0]      lim;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state: value, whether a hold session is live, its direction and
  // how many edges the button has been held since the press.
  int mq[3];
  int hn[3];
  bit sess[3];
  bit sdir[3];
  bit psoma, psub, armed;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic int get_q(input int i);
    case (i)
      0:       return int'(q0);
      1:       return int'(q1);
      default: return int'(q2);
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit c, input bit l, input int d,
                            input bit e, input bit s, input bit b);
    exp_t x;
    x = '0;
    for (int i = 0; i < 3; i++) begin
      bit m, lm, st, up, valid, press;
      int dv;
      m = 0; lm = 0; st = 0; up = s; valid = s ^ b;
      press = s ? (s && !psoma) : (b && !psub);
      if (r || c) begin
        mq[i] = cmin[i];
        sess[i] = 0;
      end else if (l) begin
        dv = d % (1 << cw[i]);
        mq[i] = (dv < cmin[i]) ? cmin[i] : (dv > cmax[i]) ? cmax[i] : dv;
        sess[i] = 0;
      end else if (sess[i]) begin
        if (!e || !valid || up != sdir[i]) begin
          sess[i] = 0;
        end else begin
          hn[i]++;
          if (hn[i] == crd[i] || (hn[i] > crd[i] && (hn[i] - crd[i]) % crp[i] == 0)) st = 1;
        end
      end else if (e && valid && press && armed) begin
        st = 1;
        sdir[i] = up;
        if (crd[i] > 0) begin
          sess[i] = 1;
          hn[i] = 0;
        end
      end
      if (st) begin
        if (sdir[i]) begin
          if (mq[i] + cstep[i] <= cmax[i]) begin mq[i] += cstep[i]; m = 1; end
          else if (cwrap[i] != 0) begin mq[i] = cmin[i]; m = 1; lm = 1; end
          else begin m = (mq[i] != cmax[i]); mq[i] = cmax[i]; lm = 1; end
        end else begin
          if (mq[i] - cstep[i] >= cmin[i]) begin mq[i] -= cstep[i]; m = 1; end
          else if (cwrap[i] != 0) begin mq[i] = cmax[i]; m = 1; lm = 1; end
          else begin m = (mq[i] != cmin[i]); mq[i] = cmin[i]; lm = 1; end
        end
      end
      x.q[i] = 4'(mq[i]);
      x.mud[i] = m;
      x.lim[i] = lm;
    end
    if (r) begin
      psoma = 0; psub = 0; armed = 0;
    end else begin
      psoma = s; psub = b; armed = 1;
    end
    sb.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit c, input bit l, input int d,
                     input bit e, input bit s, input bit b);
    @(negedge clock);
    #1;
    reset = r; clr = c; ld = l; d_in = 4'(d); enp = e; soma = s; sub = b;
    model_edge(r, c, l, d, e, s, b);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic press(input bit s, input bit b);
    cyc(0, 0, 0, 0, 1, s, b);
    cyc(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("Q[%0d]@%0t", i, $time), get_q(i), int'(x.q[i]));
        chk($sformatf("mudou[%0d]@%0t", i, $time), int'(mud[i]), int'(x.mud[i]));
        chk($sformatf("limite[%0d]@%0t", i, $time), int'(lim[i]), int'(x.lim[i]));
        chk($sformatf("no_max[%0d]@%0t", i, $time), int'(nmax[i]), (int'(x.q[i]) == cmax[i]) ? 1 : 0);
        chk($sformatf("no_min[%0d]@%0t", i, $time), int'(nmin[i]), (int'(x.q[i]) == cmin[i]) ? 1 : 0);
      end
    end
  end

  initial begin
    bit hs, hb;
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1, 0, 0);
    idle(2);
    settle();
    chk("reset_q0", int'(q0), 1);
    chk("reset_no_min0", int'(nmin[0]), 1);

    for (int k = 0; k < 5; k++) press(1, 0);
    settle();
    chk("five_up_q0", int'(q0), 5);
    chk("five_up_no_max0", int'(nmax[0]), 1);
    chk("five_up_q2", int'(q2), 13);

    cyc(0, 0, 1, 5, 1, 0, 0);
    press(1, 0);
    settle();
    chk("wrap_up_q1", int'(q1), 1);
    press(0, 1);
    settle();
    chk("wrap_dn_q1", int'(q1), 5);

    cyc(0, 0, 1, 7, 1, 0, 0);
    settle();
    chk("ld7_q0", int'(q0), 5);
    chk("ld7_q2", int'(q2), 7);
    cyc(0, 0, 1, 0, 1, 0, 0);
    settle();
    chk("ld0_q0", int'(q0), 1);
    chk("ld0_q2", int'(q2), 2);
    cyc(0, 0, 1, 4, 1, 0, 0);
    cyc(0, 1, 1, 3, 1, 0, 0);
    settle();
    chk("clr_over_ld_q0", int'(q0), 1);
    cyc(0, 0, 1, 3, 1, 0, 0);
    press(1, 1);
    idle(1);

    cyc(0, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 1, 1, 0);
    settle();
    chk("repeat_q0", int'(q0), 5);
    idle(4);

    cyc(0, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 1, 0);
    settle();
    chk("enp_held_q0", int'(q0), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    press(1, 0);
    settle();
    chk("enp_repress_q0", int'(q0), 2);

    cyc(0, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 1, 1, 0);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("async_rst_q[%0d]", i), get_q(i), cmin[i]);
      chk($sformatf("async_rst_mudou[%0d]", i), int'(mud[i]), 0);
      chk($sformatf("async_rst_limite[%0d]", i), int'(lim[i]), 0);
    end
    cyc(1, 0, 0, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 1, 0);
    settle();
    chk("held_after_rst_q0", int'(q0), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    press(1, 0);
    settle();
    chk("repress_after_rst_q0", int'(q0), 2);

    hs = 0; hb = 0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) hs = ~hs;
      if ($urandom_range(0, 7) == 0) hb = ~hb;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
          int'($urandom_range(0, 15)), $urandom_range(0, 9) != 0, hs, hb);
    end
    idle(2);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
